// File: rtl/matrix_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : matrix_pkg                                             |
// | Description : Shared types for the matrix loader: FSM state enum,    |
// |               read-select encodings and the default element type.    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package matrix_pkg;

  // Element width the multiply array is built for; modules may override it.
  localparam int ELEM_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2,
    READY  = 2'd3
  } loader_state_t;

  localparam logic SEL_A_ROW = 1'b0;
  localparam logic SEL_B_COL = 1'b1;

  typedef logic [ELEM_W_DEFAULT-1:0] elem_t;

endpackage
`default_nettype wire

// File: rtl/matrix_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : matrix_bank                                            |
// | Description : MAX_DIM x MAX_DIM flop array of ELEM_W elements with   |
// |               one write port and combinational row/column slices.    |
// | Ports       : clk_i        clock                                     |
// |               we_i         write enable                              |
// |               wr_row_i/wr_col_i/wr_data_i  write address and data    |
// |               rd_row_i     row index for row_o                       |
// |               rd_col_i     column index for col_o                    |
// |               row_o        lane c = mem[rd_row_i][c]                 |
// |               col_o        lane r = mem[r][rd_col_i]                 |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module matrix_bank #(
  parameter int ELEM_W  = 8,
  parameter int MAX_DIM = 8,
  parameter int IDX_W   = $clog2(MAX_DIM + 1)
) (
  input  logic                      clk_i,
  input  logic                      we_i,
  input  logic [IDX_W-1:0]          wr_row_i,
  input  logic [IDX_W-1:0]          wr_col_i,
  input  logic [ELEM_W-1:0]         wr_data_i,
  input  logic [IDX_W-1:0]          rd_row_i,
  input  logic [IDX_W-1:0]          rd_col_i,
  output logic [MAX_DIM*ELEM_W-1:0] row_o,
  output logic [MAX_DIM*ELEM_W-1:0] col_o
);

  // Contents are never reset; the loader masks anything not freshly written.
  logic [ELEM_W-1:0] mem_q [MAX_DIM][MAX_DIM];

  always_ff @(posedge clk_i) begin
    for (int r = 0; r < MAX_DIM; r++) begin
      for (int c = 0; c < MAX_DIM; c++) begin
        if (we_i && (wr_row_i == IDX_W'(r)) && (wr_col_i == IDX_W'(c))) begin
          mem_q[r][c] <= wr_data_i;
        end
      end
    end
  end

  // Index compares instead of direct indexing keep out-of-range indices
  // (IDX_W can address past MAX_DIM) from selecting anything.
  always_comb begin
    row_o = '0;
    col_o = '0;
    for (int r = 0; r < MAX_DIM; r++) begin
      for (int c = 0; c < MAX_DIM; c++) begin
        if (rd_row_i == IDX_W'(r)) row_o[c*ELEM_W +: ELEM_W] = mem_q[r][c];
        if (rd_col_i == IDX_W'(c)) col_o[r*ELEM_W +: ELEM_W] = mem_q[r][c];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/matrix_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : matrix_loader                                          |
// | Description : Takes a dimension header on start, loads A then B      |
// |               (row-major) from a valid/ready stream, then serves     |
// |               packed A rows / B columns one cycle after a request.   |
// | Ports       : inter_refclk, rst_in (async, active-high)              |
// |               start, a_rows, a_cols, b_cols    dimension header      |
// |               in_valid, in_data, in_ready      element stream        |
// |               load_done (level), cfg_err (pulse)                     |
// |               rd_req, rd_sel, rd_idx           read request          |
// |               rd_valid, rd_err, rd_vec         registered response   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module matrix_loader
  import matrix_pkg::*;
#(
  parameter int ELEM_W  = 8,
  parameter int MAX_DIM = 8,
  parameter int IDX_W   = $clog2(MAX_DIM + 1)
) (
  input  logic                      inter_refclk,
  input  logic                      rst_in,
  input  logic                      start,
  input  logic [IDX_W-1:0]          a_rows,
  input  logic [IDX_W-1:0]          a_cols,
  input  logic [IDX_W-1:0]          b_cols,
  input  logic                      in_valid,
  input  logic [ELEM_W-1:0]         in_data,
  output logic                      in_ready,
  output logic                      load_done,
  output logic                      cfg_err,
  input  logic                      rd_req,
  input  logic                      rd_sel,
  input  logic [IDX_W-1:0]          rd_idx,
  output logic                      rd_valid,
  output logic                      rd_err,
  output logic [MAX_DIM*ELEM_W-1:0] rd_vec
);

  localparam logic [IDX_W-1:0] C_IDX_ONE = IDX_W'(1);

  loader_state_t state_q, state_d;
  logic [IDX_W-1:0] row_q, row_d, col_q, col_d;
  logic [IDX_W-1:0] a_rows_q, a_rows_d, a_cols_q, a_cols_d, b_cols_q, b_cols_d;
  logic in_ready_q, in_ready_d, load_done_q, load_done_d, cfg_err_q, cfg_err_d;
  logic rd_valid_q, rd_err_q, rd_err_d;
  logic [MAX_DIM*ELEM_W-1:0] rd_vec_q, rd_vec_d;

  logic accept, we_a, we_b, start_ok, rd_bad;
  logic [MAX_DIM*ELEM_W-1:0] a_row_vec, a_col_vec, b_row_vec, b_col_vec;
  logic unused_slices;

  function automatic logic dim_ok(input logic [IDX_W-1:0] d);
    return (d != '0) && (d <= IDX_W'(MAX_DIM));
  endfunction

  assign start_ok = dim_ok(a_rows) && dim_ok(a_cols) && dim_ok(b_cols);
  assign accept   = in_valid && in_ready_q;

  matrix_bank #(.ELEM_W(ELEM_W), .MAX_DIM(MAX_DIM), .IDX_W(IDX_W)) u_bank_a (
    .clk_i(inter_refclk), .we_i(we_a), .wr_row_i(row_q), .wr_col_i(col_q),
    .wr_data_i(in_data), .rd_row_i(rd_idx), .rd_col_i(rd_idx),
    .row_o(a_row_vec), .col_o(a_col_vec)
  );

  matrix_bank #(.ELEM_W(ELEM_W), .MAX_DIM(MAX_DIM), .IDX_W(IDX_W)) u_bank_b (
    .clk_i(inter_refclk), .we_i(we_b), .wr_row_i(row_q), .wr_col_i(col_q),
    .wr_data_i(in_data), .rd_row_i(rd_idx), .rd_col_i(rd_idx),
    .row_o(b_row_vec), .col_o(b_col_vec)
  );

  // Only A rows and B columns are ever served.
  assign unused_slices = ^{a_col_vec, b_row_vec};

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    a_rows_d  = a_rows_q;
    a_cols_d  = a_cols_q;
    b_cols_d  = b_cols_q;
    we_a      = 1'b0;
    we_b      = 1'b0;
    cfg_err_d = 1'b0;
    case (state_q)
      IDLE, READY: begin
        if (start) begin
          if (!start_ok) begin
            cfg_err_d = 1'b1;
            state_d   = IDLE;
          end else begin
            a_rows_d = a_rows;
            a_cols_d = a_cols;
            b_cols_d = b_cols;
            row_d    = '0;
            col_d    = '0;
            state_d  = LOAD_A;
          end
        end
      end
      LOAD_A: begin
        if (accept) begin
          we_a = 1'b1;
          if (col_q == a_cols_q - C_IDX_ONE) begin
            col_d = '0;
            if (row_q == a_rows_q - C_IDX_ONE) begin
              row_d   = '0;
              state_d = LOAD_B;
            end else begin
              row_d = row_q + C_IDX_ONE;
            end
          end else begin
            col_d = col_q + C_IDX_ONE;
          end
        end
      end
      LOAD_B: begin
        // B has a_cols rows and b_cols columns.
        if (accept) begin
          we_b = 1'b1;
          if (col_q == b_cols_q - C_IDX_ONE) begin
            col_d = '0;
            if (row_q == a_cols_q - C_IDX_ONE) begin
              row_d   = '0;
              state_d = READY;
            end else begin
              row_d = row_q + C_IDX_ONE;
            end
          end else begin
            col_d = col_q + C_IDX_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Decoded from the next state so these are plain flops at the port.
    in_ready_d  = (state_d == LOAD_A) || (state_d == LOAD_B);
    load_done_d = (state_d == READY);
  end

  always_comb begin
    // A start seen in READY takes the loader out of READY on this edge,
    // so a coincident read is refused.
    rd_bad = (state_q != READY) || start ||
             ((rd_sel == SEL_A_ROW) ? (rd_idx >= a_rows_q) : (rd_idx >= b_cols_q));
    rd_err_d = rd_req && rd_bad;
    rd_vec_d = '0;
    if (rd_req && !rd_bad) begin
      for (int k = 0; k < MAX_DIM; k++) begin
        // Lanes past a_cols may hold stale data from an earlier load.
        if (IDX_W'(k) < a_cols_q) begin
          rd_vec_d[k*ELEM_W +: ELEM_W] = (rd_sel == SEL_A_ROW) ?
              a_row_vec[k*ELEM_W +: ELEM_W] : b_col_vec[k*ELEM_W +: ELEM_W];
        end
      end
    end
  end

  always_ff @(posedge inter_refclk or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      a_rows_q    <= '0;
      a_cols_q    <= '0;
      b_cols_q    <= '0;
      in_ready_q  <= 1'b0;
      load_done_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_err_q    <= 1'b0;
      rd_vec_q    <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      a_rows_q    <= a_rows_d;
      a_cols_q    <= a_cols_d;
      b_cols_q    <= b_cols_d;
      in_ready_q  <= in_ready_d;
      load_done_q <= load_done_d;
      cfg_err_q   <= cfg_err_d;
      rd_valid_q  <= rd_req;
      rd_err_q    <= rd_err_d;
      rd_vec_q    <= rd_vec_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign load_done = load_done_q;
  assign cfg_err   = cfg_err_q;
  assign rd_valid  = rd_valid_q;
  assign rd_err    = rd_err_q;
  assign rd_vec    = rd_vec_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_matrix_loader                                       |
// | Description : Self-checking bench for matrix_loader (ELEM_W=8,       |
// |               MAX_DIM=4): directed sequences, a read table and       |
// |               randomized loads against a flat-array reference model. |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_matrix_loader;

  localparam int EW = 8;
  localparam int MD = 4;
  localparam int IW = 3;
  localparam int VW = MD * EW;

  logic          clk = 1'b0;
  logic          rst_in;
  logic          start;
  logic [IW-1:0] a_rows, a_cols, b_cols;
  logic          in_valid;
  logic [EW-1:0] in_data;
  logic          in_ready, load_done, cfg_err;
  logic          rd_req, rd_sel;
  logic [IW-1:0] rd_idx;
  logic          rd_valid, rd_err;
  logic [VW-1:0] rd_vec;

  matrix_loader #(.ELEM_W(EW), .MAX_DIM(MD)) dut (
    .inter_refclk(clk), .rst_in(rst_in), .start(start),
    .a_rows(a_rows), .a_cols(a_cols), .b_cols(b_cols),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .load_done(load_done), .cfg_err(cfg_err),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_idx(rd_idx),
    .rd_valid(rd_valid), .rd_err(rd_err), .rd_vec(rd_vec)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: 0 = idle, 1 = loading, 2 = ready. Elements are kept
  // as one flat stream; A and B are addressed into it arithmetically.
  int m_state, m_cnt, m_total, m_ar, m_ac, m_bc;
  logic [EW-1:0] m_mem [32];
  logic [EW-1:0] src   [32];

  typedef struct {
    bit            sel;
    logic [IW-1:0] idx;
    bit            err;
    logic [VW-1:0] vec;
  } rd_vec_t;
  rd_vec_t tbl [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_total = 0; m_ar = 0; m_ac = 0; m_bc = 0;
  endtask

  function automatic logic [VW-1:0] model_vec(input bit sel, input int idx);
    logic [VW-1:0] v = '0;
    for (int k = 0; k < m_ac; k++)
      v[k*EW +: EW] = sel ? m_mem[m_ar*m_ac + k*m_bc + idx] : m_mem[idx*m_ac + k];
    return v;
  endfunction

  // One clock: predict from current inputs, advance model, clock, compare.
  task automatic cycle(input string tag);
    bit e_re, bad_dim;
    logic [VW-1:0] e_vec;
    bit e_cfg;
    int idx;
    if (m_state == 1) in_data = src[m_cnt];
    else              in_data = 8'($urandom);
    idx     = int'(rd_idx);
    bad_dim = (a_rows == 0) || (a_rows > MD) || (a_cols == 0) || (a_cols > MD) ||
              (b_cols == 0) || (b_cols > MD);
    e_re  = rd_req && ((m_state != 2) || start || (rd_sel ? (idx >= m_bc) : (idx >= m_ar)));
    e_vec = (rd_req && !e_re) ? model_vec(rd_sel, idx) : '0;
    e_cfg = start && (m_state != 1) && bad_dim;
    if (start && (m_state != 1)) begin
      if (bad_dim) m_state = 0;
      else begin
        m_ar = int'(a_rows); m_ac = int'(a_cols); m_bc = int'(b_cols);
        m_total = m_ar*m_ac + m_ac*m_bc; m_cnt = 0; m_state = 1;
      end
    end else if ((m_state == 1) && in_valid) begin
      m_mem[m_cnt] = in_data;
      m_cnt++;
      if (m_cnt == m_total) m_state = 2;
    end
    @(posedge clk); #1;
    chk({tag, ".in_ready"},  in_ready,  m_state == 1);
    chk({tag, ".load_done"}, load_done, m_state == 2);
    chk({tag, ".cfg_err"},   cfg_err,   e_cfg);
    chk({tag, ".rd_valid"},  rd_valid,  rd_req);
    chk({tag, ".rd_err"},    rd_err,    e_re);
    chk({tag, ".rd_vec"},    rd_vec,    e_vec);
  endtask

  task automatic do_start(input int ar, input int ac, input int bc);
    start = 1'b1; a_rows = IW'(ar); a_cols = IW'(ac); b_cols = IW'(bc);
    cycle("start");
    start = 1'b0;
  endtask

  // mode 0: in_valid held; 1: 1-0-0-1 bursts; 2: random valid plus stray
  // reads and ignored starts.
  task automatic load_stream(input string tag, input int mode, input int budget);
    int c = 0;
    while ((m_state == 1) && (c < budget)) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = ((c % 4) == 0) || ((c % 4) == 3);
        default: begin
          in_valid = ($urandom_range(3) != 0);
          rd_req   = ($urandom_range(3) == 0);
          rd_sel   = 1'($urandom);
          rd_idx   = IW'($urandom_range(5));
          start    = ($urandom_range(15) == 0);
          a_rows   = IW'($urandom_range(5));
          a_cols   = IW'($urandom_range(5));
          b_cols   = IW'($urandom_range(5));
        end
      endcase
      cycle(tag);
      c++;
    end
    in_valid = 1'b0; rd_req = 1'b0; start = 1'b0;
    if (m_state == 1) begin
      total++; bad++;
      $display("FAIL %s.budget: load unfinished after %0d cycles, required done", tag, budget);
    end
  endtask

  task automatic read_tbl(input int i);
    rd_req = 1'b1; rd_sel = tbl[i].sel; rd_idx = tbl[i].idx;
    cycle($sformatf("tbl%0d", i));
    rd_req = 1'b0;
    chk($sformatf("tbl%0d.valid", i), rd_valid, 1'b1);
    chk($sformatf("tbl%0d.err", i),   rd_err,   tbl[i].err);
    chk($sformatf("tbl%0d.vec", i),   rd_vec,   tbl[i].vec);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 3'd0, 1'b0, 32'h0003_0201};
    tbl[1] = '{1'b0, 3'd1, 1'b0, 32'h0006_0504};
    tbl[2] = '{1'b0, 3'd2, 1'b1, 32'h0000_0000};
    tbl[3] = '{1'b1, 3'd0, 1'b0, 32'h000B_0907};
    tbl[4] = '{1'b1, 3'd1, 1'b0, 32'h000C_0A08};
    tbl[5] = '{1'b1, 3'd2, 1'b1, 32'h0000_0000};
    tbl[6] = '{1'b0, 3'd7, 1'b1, 32'h0000_0000};

    rst_in = 1'b1; start = 1'b0; a_rows = '0; a_cols = '0; b_cols = '0;
    in_valid = 1'b0; in_data = '0; rd_req = 1'b0; rd_sel = 1'b0; rd_idx = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready", in_ready, 1'b0);
    chk("rst.load_done", load_done, 1'b0);
    chk("rst.cfg_err", cfg_err, 1'b0);
    chk("rst.rd_valid", rd_valid, 1'b0);
    chk("rst.rd_err", rd_err, 1'b0);
    chk("rst.rd_vec", rd_vec, '0);
    rst_in = 1'b0;

    // Basic load: 2x3 A, 3x2 B, elements 1..12, valid held.
    for (int i = 0; i < 12; i++) src[i] = 8'(i + 1);
    do_start(2, 3, 2);
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle("basic");
      if (i == 10) chk("basic.done_early", load_done, 1'b0);
    end
    in_valid = 1'b0;
    chk("basic.done", load_done, 1'b1);
    chk("basic.ready_low", in_ready, 1'b0);
    for (int i = 0; i < 7; i++) read_tbl(i);

    // Bursty input, same data.
    do_start(2, 3, 2);
    load_stream("bursty", 1, 60);
    read_tbl(1);
    read_tbl(4);

    // Reads while loading, including on the final accept.
    do_start(2, 3, 2);
    in_valid = 1'b1; rd_req = 1'b1; rd_sel = 1'b1; rd_idx = '0;
    cycle("rd_load_a");
    rd_req = 1'b0;
    chk("rd_load_a.err", rd_err, 1'b1);
    chk("rd_load_a.vec", rd_vec, '0);
    for (int i = 0; i < 10; i++) cycle("rd_load");
    rd_req = 1'b1; rd_sel = 1'b0; rd_idx = '0;
    cycle("rd_final");
    rd_req = 1'b0; in_valid = 1'b0;
    chk("rd_final.err", rd_err, 1'b1);
    chk("rd_final.done", load_done, 1'b1);

    // Bad dimensions.
    do_start(2, 0, 2);
    chk("bad0.cfg_err", cfg_err, 1'b1);
    chk("bad0.in_ready", in_ready, 1'b0);
    chk("bad0.load_done", load_done, 1'b0);
    cycle("bad0_gap");
    chk("bad0.pulse_end", cfg_err, 1'b0);
    do_start(2, 3, 5);
    chk("bad5.cfg_err", cfg_err, 1'b1);
    chk("bad5.in_ready", in_ready, 1'b0);
    cycle("bad5_gap");
    chk("bad5.pulse_end", cfg_err, 1'b0);
    rd_req = 1'b1; rd_sel = 1'b0; rd_idx = '0;
    cycle("rd_idle");
    rd_req = 1'b0;
    chk("rd_idle.err", rd_err, 1'b1);

    // Reset in the middle of loading.
    do_start(2, 3, 2);
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) cycle("pre_rst");
    rst_in = 1'b1; in_valid = 1'b0;
    #2;
    chk("midrst.in_ready", in_ready, 1'b0);
    chk("midrst.load_done", load_done, 1'b0);
    chk("midrst.cfg_err", cfg_err, 1'b0);
    chk("midrst.rd_valid", rd_valid, 1'b0);
    chk("midrst.rd_err", rd_err, 1'b0);
    chk("midrst.rd_vec", rd_vec, '0);
    @(posedge clk); #1;
    rst_in = 1'b0;
    model_reset();
    src[0] = 8'd9; src[1] = 8'd7;
    do_start(1, 1, 1);
    load_stream("tiny", 0, 10);
    rd_req = 1'b1; rd_sel = 1'b0; rd_idx = '0;
    cycle("tiny_a");
    chk("tiny_a.vec", rd_vec, 32'h0000_0009);
    rd_sel = 1'b1;
    cycle("tiny_b");
    rd_req = 1'b0;
    chk("tiny_b.vec", rd_vec, 32'h0000_0007);

    // Reload from READY together with a read.
    for (int i = 0; i < 4; i++) src[i] = 8'($urandom);
    rd_req = 1'b1; rd_sel = 1'b0; rd_idx = '0;
    do_start(1, 2, 1);
    rd_req = 1'b0;
    chk("reload.rd_err", rd_err, 1'b1);
    chk("reload.done_fall", load_done, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) cycle("reload");
    chk("reload.done_early", load_done, 1'b0);
    cycle("reload_last");
    in_valid = 1'b0;
    chk("reload.done", load_done, 1'b1);

    // Randomized loads and reads.
    for (int it = 0; it < 25; it++) begin
      int ar, ac, bc;
      ar = $urandom_range(1, 4); ac = $urandom_range(1, 4); bc = $urandom_range(1, 4);
      if ($urandom_range(7) == 0) bc = ($urandom_range(1) == 0) ? 0 : 5;
      for (int i = 0; i < 32; i++) src[i] = 8'($urandom);
      do_start(ar, ac, bc);
      if (m_state == 1) load_stream($sformatf("rnd%0d", it), 2, 400);
      for (int r = 0; r < 6; r++) begin
        rd_req = ($urandom_range(3) != 0);
        rd_sel = 1'($urandom);
        rd_idx = IW'($urandom_range(5));
        cycle($sformatf("rnd%0d.rd", it));
      end
      rd_req = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/matrix_loader.md
# matrix_loader

Parametrised successor to the single-row matrix compiler. It accepts a dimension header on `start`, then a valid/ready element stream holding matrix A followed by matrix B, both row-major, and stores both in a register bank. Once loaded, it serves packed A rows or packed B columns on request, one cycle after the request. It sits between the ingress byte path and the multiply array.

## Interface
- `ELEM_W`, default 8: element width in bits.
- `MAX_DIM`, default 8: maximum rows or cols of A and B, at least 2.
- `IDX_W`, default `$clog2(MAX_DIM+1)`: width of dimension and index fields.

Ports:
- `inter_refclk`  in  1  the single clock.
- `rst_in`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle pulse that samples the dimensions.
- `a_rows`, `a_cols`, `b_cols`  in  IDX_W each  dimensions; B has `a_cols` rows.
- `in_valid`  in  1  element valid.
- `in_data`  in  ELEM_W  element.
- `in_ready`  out  1  loader accepts an element this cycle.
- `load_done`  out  1  level; both matrices are loaded.
- `cfg_err`  out  1  one-cycle pulse: `start` rejected.
- `rd_req`  in  1  read request pulse.
- `rd_sel`  in  1  0 = A row, 1 = B column.
- `rd_idx`  in  IDX_W  row or column index.
- `rd_valid`  out  1  response pulse.
- `rd_err`  out  1  qualifies `rd_valid`: the request was invalid.
- `rd_vec`  out  MAX_DIM*ELEM_W  lane k is bits `[k*ELEM_W +: ELEM_W]`.

## Operation
- States:
  - IDLE: waits for `start`.
  - LOAD_A: accepts A elements.
  - LOAD_B: accepts B elements.
  - READY: serves reads.
- `start` in IDLE or READY:
  - Any dimension equal to 0 or greater than MAX_DIM: pulse `cfg_err`, go to or stay in IDLE, clear `load_done`.
  - Otherwise: latch the dimensions, clear the row/col counters, clear `load_done`, go to LOAD_A.
- `start` in LOAD_A or LOAD_B is ignored.
- `in_ready` is 1 exactly in LOAD_A and LOAD_B.
  - An element is accepted on `in_valid && in_ready`.
  - It is written to bank[row][col] of the current matrix.
  - col increments; at `a_cols-1` (A) or `b_cols-1` (B) col wraps to 0 and row increments.
- Leaving the load states:
  - Last A element (row `a_rows-1`, col `a_cols-1`): go to LOAD_B with the counters cleared, no bubble.
  - Last B element (row `a_cols-1`, col `b_cols-1`): go to READY.
- Read response:
  - `rd_req` produces `rd_valid` exactly one cycle later, in every state.
  - The request is an error if the state is not READY, or if `rd_idx` is at or above `a_rows` (A) or `b_cols` (B).
  - On error: `rd_err`=1 and `rd_vec`=0.
  - Otherwise, A row: lane k = A[idx][k] for k < `a_cols`.
  - Otherwise, B column: lane k = B[k][idx] for k < `a_cols`.
  - Lanes at or above `a_cols` are 0.
- Bank contents are not cleared on reload. Stale entries are never visible because lanes are masked.
- Arithmetic: counters are IDX_W bits wide and there is no arithmetic on data.

## Timing
- Reset values:
  - State is IDLE.
  - `in_ready`, `load_done`, `cfg_err`, `rd_valid`, `rd_err` = 0.
  - `rd_vec` = 0.
  - Counters and latched dimensions = 0.
  - Bank contents are don't-care.
- Reset asserted mid-load aborts immediately; the next `start` begins fresh.
- Sustained `in_valid` gives one element per cycle; total load time is `a_rows*a_cols + a_cols*b_cols` cycles.
- `load_done` rises in the cycle after the final B accept.
- `rd_req` in the same cycle as the final B accept returns `rd_err`=1, because the state is not yet READY.
- `start` and `rd_req` in the same cycle in READY:
  - The read completes with `rd_err`=1.
  - `load_done` falls the next cycle.
- All outputs are registered. There is no combinational path from input to output.

## Structure
- Package `matrix_pkg` holds:
  - the `loader_state_t` enum {IDLE, LOAD_A, LOAD_B, READY};
  - `SEL_A_ROW`=1'b0 and `SEL_B_COL`=1'b1;
  - `elem_t` sized by ELEM_W.
- Sub-module `matrix_bank`, instantiated twice (A and B):
  - MAX_DIM×MAX_DIM×ELEM_W flop array;
  - write port: row, col, data, we;
  - combinational row-slice and column-slice read outputs.
- Top level: FSM, counters, dimension checks, lane masking, registered response.

## Test plan
All tests use ELEM_W=8, MAX_DIM=4.
- **Basic load and read.**
  - Stimulus: `start` with a_rows=2, a_cols=3, b_cols=2; stream 1..12 with `in_valid` held high.
  - Required: `load_done` rises after the 12th accept.
  - A row 1 gives lanes {4,5,6,0}.
  - B column 1 gives lanes {8,10,12,0}.
- **Bursty input.**
  - Stimulus: same data as basic load, with `in_valid` toggled in a 1-0-0-1 pattern.
  - Required: identical read results; the cycle of `load_done` tracks the 12th accept.
- **Bad dimensions.**
  - Stimulus: `start` with a_cols=0, then `start` with b_cols=5.
  - Required: one `cfg_err` pulse each; state stays IDLE; `in_ready`=0.
- **Bad reads.**
  - Stimulus: after the basic load, read A row 2; also read B column 0 while in LOAD_A.
  - Required: `rd_valid`=1, `rd_err`=1, `rd_vec`=0.
- **Reset mid-load.**
  - Stimulus: assert `rst_in` after 8 accepts, then do a fresh 1×1×1 load with elements 9 and 7.
  - Required: all outputs are 0 during reset.
  - A row 0 lane 0 = 9; B column 0 lane 0 = 7.
- **Reload.**
  - Stimulus: `start` in READY with 1×2×1 dimensions, concurrent with `rd_req`.
  - Required: the read returns `rd_err`; `load_done` drops next cycle and re-rises after 4 accepts.
